pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard controller for the 5-stage core. Drives stall/flush for the four
//  pipeline registers (i2d, d2e, e2m, m2w) and PC hold/redirect from miss, load-use and
//  mispredict causes. Sequences a pipeline-drain handshake (ll/sc, halt). Keeps a stall
//  watchdog and wrapping perf counters.
// PARAMETERS
//  DRAIN_CYCLES  4     advancing cycles after fetch stop until pipeline is empty
//  TIMEOUT       1024  consecutive pc_stall cycles in RUN that set o_hang
//  CNT_W         32    perf counter width
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      async reset, active low
//  i_ic_miss      in   1      i-cache output not valid for current fetch
//  i_dc_miss      in   1      valid M-stage access not yet served
//  i_load_use     in   1      D-stage source matches E-stage load destination
//  i_br_mispred   in   1      E-stage branch resolved against prediction (level)
//  i_drain_req    in   1      request empty pipeline; level, held until ack seen
//  o_pc_stall     out  1      hold PC
//  o_pc_redirect  out  1      PC loads recovery target; overrides o_pc_stall
//  o_i2d_stall / o_i2d_flush  out 1 each   pr_i2d control
//  o_d2e_stall / o_d2e_flush  out 1 each   pr_d2e control
//  o_e2m_stall / o_e2m_flush  out 1 each   pr_e2m control
//  o_m2w_stall / o_m2w_flush  out 1 each   pr_m2w control
//  o_drain_ack    out  1      pipeline empty, fetch held
//  o_hang         out  1      sticky watchdog flag
//  o_stall_cycles out  CNT_W  cycles with o_pc_stall or any *_stall high
//  o_mispredicts  out  CNT_W  cycles with o_pc_redirect high
// BEHAVIOUR
//  Reset: state RUN, drain counter/watchdog/perf counters 0, o_hang 0, o_drain_ack 0;
//   while rst_n low every output is 0.
//  Stall/flush/pc outputs are combinational, zero latency, from inputs + state.
//  Never assert stall and flush on the same register (register ignores flush if stalled).
//  Priority (first match wins; unlisted controls 0):
//   1 i_dc_miss: pc_stall, i2d/d2e/e2m_stall =1; m2w_flush =1 (bubble into WB).
//   2 i_br_mispred: pc_redirect, i2d_flush, d2e_flush =1; ic_miss/load_use ignored.
//   3 i_load_use: pc_stall, i2d_stall =1; d2e_flush =1.
//   4 i_ic_miss: pc_stall =1; i2d_flush =1.
//  FSM RUN/DRAIN/DRAINED:
//   RUN->DRAIN when i_drain_req=1; drain counter cleared.
//   DRAIN: additionally pc_stall=1 and i2d_flush=1 unless rule 1 stalls i2d. Counter
//    +1 on each cycle with i_dc_miss=0; at DRAIN_CYCLES -> DRAINED. Mispredict in DRAIN
//    still redirects PC (rule 2); counter not restarted.
//   DRAINED: o_drain_ack=1, pc_stall=1, i2d_flush=1; -> RUN when i_drain_req=0
//    (ack drops same edge).
//   i_drain_req dropped during DRAIN -> RUN next edge, no ack.
//  Watchdog: run counter +1 each RUN cycle with o_pc_stall=1 and o_pc_redirect=0, else
//   cleared; counter saturates; reaching TIMEOUT sets o_hang until reset. DRAIN/DRAINED
//   clear counter.
//  Perf counters: +1 per qualifying cycle, wrap mod 2^CNT_W, no saturation.
//  Simultaneous dc_miss+mispred: only rule 1; mispred honoured on the first
//   cycle dc_miss is low (E held, level still present).
//  Async reset mid-DRAIN returns to RUN with ack 0.
// TESTING
//  T1 i_load_use=1 one cycle -> pc_stall,i2d_stall,d2e_flush=1 that cycle; 0 next.
//  T2 dc_miss 3 cycles with br_mispred=1 -> 3 cycles rule 1 (m2w_flush=1), then one
//     cycle pc_redirect=1,i2d/d2e_flush=1; o_mispredicts=1, o_stall_cycles=3.
//  T3 drain_req=1, no misses -> DRAINED after 4 edges, o_drain_ack=1; req=0 -> RUN, ack 0.
//  T4 drain_req=1 with dc_miss 2 cycles inside DRAIN -> ack after 6 edges, i2d_flush
//     0 during miss cycles.
//  T5 TIMEOUT=8, ic_miss held 8 cycles -> o_hang=1 at 8th edge, stays 1 after ic_miss=0.
//  T6 CNT_W=4, 17 stall cycles -> o_stall_cycles=1 (wrap); rst_n low mid-DRAIN -> all 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage core and its hazard controller.
// The hazard controller uses the master modport: it receives hazard causes and drives pipeline controls.
// The pipeline (or a bench) uses the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard causes from the pipeline.
  logic             i_ic_miss;
  logic             i_dc_miss;
  logic             i_load_use;
  logic             i_br_mispred;
  logic             i_drain_req;

  // PC and pipeline-register controls.
  logic             o_pc_stall;
  logic             o_pc_redirect;
  logic             o_i2d_stall;
  logic             o_i2d_flush;
  logic             o_d2e_stall;
  logic             o_d2e_flush;
  logic             o_e2m_stall;
  logic             o_e2m_flush;
  logic             o_m2w_stall;
  logic             o_m2w_flush;

  // Drain handshake, watchdog and performance counters.
  logic             o_drain_ack;
  logic             o_hang;
  logic [CNT_W-1:0] o_stall_cycles;
  logic [CNT_W-1:0] o_mispredicts;

  modport master (
    input  i_ic_miss, i_dc_miss, i_load_use, i_br_mispred, i_drain_req,
    output o_pc_stall, o_pc_redirect,
    output o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush,
    output o_e2m_stall, o_e2m_flush, o_m2w_stall, o_m2w_flush,
    output o_drain_ack, o_hang, o_stall_cycles, o_mispredicts
  );

  modport slave (
    output i_ic_miss, i_dc_miss, i_load_use, i_br_mispred, i_drain_req,
    input  o_pc_stall, o_pc_redirect,
    input  o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush,
    input  o_e2m_stall, o_e2m_flush, o_m2w_stall, o_m2w_flush,
    input  o_drain_ack, o_hang, o_stall_cycles, o_mispredicts
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage core.
// Stall/flush/PC controls are combinational from the hazard causes and the drain state.
// The drain FSM empties the pipeline for ll/sc and halt.
// A watchdog flags a PC that has been stuck in RUN.
// Two wrapping counters count stall cycles and mispredicts.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.master hz
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    drain_cnt_reg, drain_cnt_next;
  logic [WW-1:0]    wd_cnt_reg, wd_cnt_next;
  logic             hang_reg, hang_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] mispred_cnt_reg, mispred_cnt_next;

  logic pc_stall, pc_redirect;
  logic i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic e2m_stall, e2m_flush, m2w_stall, m2w_flush;
  logic any_stall;

  // Hazard priority: a D-cache miss freezes everything up to M.
  // A mispredict cannot take effect until E is allowed to move.
  always_comb begin
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    i2d_stall   = 1'b0;
    i2d_flush   = 1'b0;
    d2e_stall   = 1'b0;
    d2e_flush   = 1'b0;
    e2m_stall   = 1'b0;
    e2m_flush   = 1'b0;
    m2w_stall   = 1'b0;
    m2w_flush   = 1'b0;
    if (hz.i_dc_miss) begin
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (hz.i_br_mispred) begin
      pc_redirect = 1'b1;
      i2d_flush   = 1'b1;
      d2e_flush   = 1'b1;
    end else if (hz.i_load_use) begin
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_flush = 1'b1;
    end else if (hz.i_ic_miss) begin
      pc_stall  = 1'b1;
      i2d_flush = 1'b1;
    end
    // While draining, fetch is held and bubbles are injected into D.
    // Bubbles are not injected where i2d is already being held; a stalled register would ignore the flush.
    if (state_reg != RUN) begin
      pc_stall = 1'b1;
      if (!i2d_stall) i2d_flush = 1'b1;
    end
  end

  assign any_stall = pc_stall | i2d_stall | d2e_stall | e2m_stall | m2w_stall;

  // Drain sequencing: count only cycles in which the pipeline actually advances.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      RUN: begin
        if (hz.i_drain_req) begin
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end
      end
      DRAIN: begin
        if (!hz.i_drain_req) begin
          state_next = RUN;
        end else if (!hz.i_dc_miss) begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
          if (drain_cnt_reg == DW'(DRAIN_CYCLES - 1)) state_next = DRAINED;
        end
      end
      DRAINED: begin
        if (!hz.i_drain_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Watchdog and performance counter next values.
  // The watchdog counts consecutive held-PC cycles in RUN and saturates at TIMEOUT.
  always_comb begin
    wd_cnt_next = '0;
    if (state_reg == RUN && pc_stall && !pc_redirect) begin
      wd_cnt_next = (wd_cnt_reg == WW'(TIMEOUT)) ? wd_cnt_reg : wd_cnt_reg + 1'b1;
    end
    hang_next        = hang_reg | (wd_cnt_next == WW'(TIMEOUT));
    stall_cnt_next   = stall_cnt_reg + (any_stall ? CNT_W'(1) : CNT_W'(0));
    mispred_cnt_next = mispred_cnt_reg + (pc_redirect ? CNT_W'(1) : CNT_W'(0));
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      drain_cnt_reg   <= '0;
      wd_cnt_reg      <= '0;
      hang_reg        <= 1'b0;
      stall_cnt_reg   <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      drain_cnt_reg   <= drain_cnt_next;
      wd_cnt_reg      <= wd_cnt_next;
      hang_reg        <= hang_next;
      stall_cnt_reg   <= stall_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  // The combinational controls are forced quiet while reset is held.
  assign hz.o_pc_stall     = pc_stall    & rst_n;
  assign hz.o_pc_redirect  = pc_redirect & rst_n;
  assign hz.o_i2d_stall    = i2d_stall   & rst_n;
  assign hz.o_i2d_flush    = i2d_flush   & rst_n;
  assign hz.o_d2e_stall    = d2e_stall   & rst_n;
  assign hz.o_d2e_flush    = d2e_flush   & rst_n;
  assign hz.o_e2m_stall    = e2m_stall   & rst_n;
  assign hz.o_e2m_flush    = e2m_flush   & rst_n;
  assign hz.o_m2w_stall    = m2w_stall   & rst_n;
  assign hz.o_m2w_flush    = m2w_flush   & rst_n;
  assign hz.o_drain_ack    = (state_reg == DRAINED) & rst_n;
  assign hz.o_hang         = hang_reg;
  assign hz.o_stall_cycles = stall_cnt_reg;
  assign hz.o_mispredicts  = mispred_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// It uses small TIMEOUT/CNT_W values so that the watchdog and counter wrap are reachable.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control vector bit order:
  // {pc_stall, pc_redirect, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f}
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_DCM   = 10'b1010101001;
  localparam logic [9:0] C_MISP  = 10'b0101010000;
  localparam logic [9:0] C_LDU   = 10'b1010010000;
  localparam logic [9:0] C_ICM   = 10'b1001000000;
  localparam logic [9:0] C_DRAIN = 10'b1001000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(4),
    .TIMEOUT     (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus.master)
  );

  always #5 clk = ~clk;

  logic [9:0] ctl;
  assign ctl = {bus.o_pc_stall, bus.o_pc_redirect, bus.o_i2d_stall, bus.o_i2d_flush,
                bus.o_d2e_stall, bus.o_d2e_flush, bus.o_e2m_stall, bus.o_e2m_flush,
                bus.o_m2w_stall, bus.o_m2w_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ic, input logic dc, input logic lu, input logic bm, input logic dr);
    bus.i_ic_miss    = ic;
    bus.i_dc_miss    = dc;
    bus.i_load_use   = lu;
    bus.i_br_mispred = bm;
    bus.i_drain_req  = dr;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a hazard cause active to confirm that the outputs stay quiet.
    set_in(0, 1, 0, 1, 1);
    rst_n = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_ack", 32'(bus.o_drain_ack), 0);
    chk("rst_hang", 32'(bus.o_hang), 0);
    chk("rst_stallcnt", 32'(bus.o_stall_cycles), 0);
    chk("rst_mispcnt", 32'(bus.o_mispredicts), 0);
    tick();
    do_reset();
    $display("step reset: done");

    // T1: a single load-use cycle.
    set_in(0, 0, 1, 0, 0);
    #1 chk("t1_ldu", 32'(ctl), 32'(C_LDU));
    tick();
    set_in(0, 0, 0, 0, 0);
    #1 chk("t1_after", 32'(ctl), 32'(C_NONE));
    chk("t1_stallcnt", 32'(bus.o_stall_cycles), 1);
    $display("step T1: load-use");

    // Priority among the lower rules.
    set_in(1, 0, 1, 1, 0);
    #1 chk("pri_misp", 32'(ctl), 32'(C_MISP));
    set_in(1, 0, 1, 0, 0);
    #1 chk("pri_ldu", 32'(ctl), 32'(C_LDU));
    set_in(1, 0, 0, 0, 0);
    #1 chk("pri_icm", 32'(ctl), 32'(C_ICM));
    set_in(0, 0, 0, 0, 0);
    $display("step priority: mispred > load_use > ic_miss");

    // T2: a D-cache miss overlapping a mispredict.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 1, 0);
      #1 chk("t2_dcm", 32'(ctl), 32'(C_DCM));
      tick();
    end
    set_in(0, 0, 0, 1, 0);
    #1 chk("t2_misp", 32'(ctl), 32'(C_MISP));
    tick();
    set_in(0, 0, 0, 0, 0);
    #1 chk("t2_idle", 32'(ctl), 32'(C_NONE));
    chk("t2_mispcnt", 32'(bus.o_mispredicts), 1);
    chk("t2_stallcnt", 32'(bus.o_stall_cycles), 3);
    $display("step T2: dc_miss x3 then redirect");

    // T3: clean drain. The first edge enters DRAIN, then four advancing cycles follow.
    do_reset();
    set_in(0, 0, 0, 0, 1);
    #1 chk("t3_run", 32'(ctl), 32'(C_NONE));
    tick();
    chk("t3_drain_ctl", 32'(ctl), 32'(C_DRAIN));
    chk("t3_ack_e1", 32'(bus.o_drain_ack), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_ack_early", 32'(bus.o_drain_ack), 0);
    end
    tick();
    chk("t3_ack", 32'(bus.o_drain_ack), 1);
    chk("t3_drained_ctl", 32'(ctl), 32'(C_DRAIN));
    set_in(0, 0, 0, 0, 0);
    #1 chk("t3_ack_hold", 32'(bus.o_drain_ack), 1);
    tick();
    chk("t3_ack_drop", 32'(bus.o_drain_ack), 0);
    chk("t3_run_ctl", 32'(ctl), 32'(C_NONE));
    chk("t3_stallcnt", 32'(bus.o_stall_cycles), 5);
    chk("t3_hang", 32'(bus.o_hang), 0);
    $display("step T3: drain handshake");

    // T4: the drain is extended by two D-cache miss cycles, so the ack comes after six DRAIN edges.
    do_reset();
    set_in(0, 0, 0, 0, 1);
    tick();
    tick();
    set_in(0, 1, 0, 0, 1);
    #1 chk("t4_dcm1", 32'(ctl), 32'(C_DCM));
    tick();
    chk("t4_dcm2", 32'(ctl), 32'(C_DCM));
    tick();
    set_in(0, 0, 0, 0, 1);
    tick();
    tick();
    chk("t4_ack_e6", 32'(bus.o_drain_ack), 0);
    tick();
    chk("t4_ack_e7", 32'(bus.o_drain_ack), 1);
    $display("step T4: drain stretched by dc_miss");

    // Drain request withdrawn mid-DRAIN.
    do_reset();
    set_in(0, 0, 0, 0, 1);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("abort_ctl", 32'(ctl), 32'(C_NONE));
    chk("abort_ack", 32'(bus.o_drain_ack), 0);
    $display("step abort: drain_req dropped in DRAIN");

    // T5: watchdog with TIMEOUT=8.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t5_hang_early", 32'(bus.o_hang), 0);
    end
    tick();
    chk("t5_hang", 32'(bus.o_hang), 1);
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("t5_hang_sticky", 32'(bus.o_hang), 1);
    $display("step T5: watchdog");

    // T6: 17 stall cycles on a 4-bit counter wrap to 1.
    do_reset();
    set_in(0, 1, 0, 0, 0);
    repeat (17) tick();
    set_in(0, 0, 0, 0, 0);
    #1 chk("t6_wrap", 32'(bus.o_stall_cycles), 1);
    $display("step T6: counter wrap");

    // Asynchronous reset in the middle of DRAIN.
    set_in(0, 0, 0, 0, 1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk("arst_ctl", 32'(ctl), 32'(C_NONE));
    chk("arst_ack", 32'(bus.o_drain_ack), 0);
    chk("arst_stallcnt", 32'(bus.o_stall_cycles), 0);
    tick();
    rst_n = 1'b1;
    #1 chk("arst_run", 32'(ctl), 32'(C_NONE));
    tick();
    chk("arst_redrain", 32'(ctl), 32'(C_DRAIN));
    $display("step async reset mid-DRAIN");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
